// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Clocked front end for a purely combinational 4-bit ALU.
//
//   Commands are queued in a small FIFO. One operand set at a time is
//   registered onto alu_*. The design waits SETTLE cycles, then captures
//   alu_out and offers it downstream on a valid/ready port.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no command in flight; pops the FIFO head when one exists
//   S_DRIVE | alu_* held stable, settle counter running down to 0
//   S_HOLD  | result captured, res_valid high until res_ready
module alu_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [3:0]                 cmd_in1,
  input  logic [3:0]                 cmd_in2,
  input  logic [1:0]                 cmd_opcode,
  output logic [3:0]                 alu_in1,
  output logic [3:0]                 alu_in2,
  output logic [1:0]                 alu_opcode,
  input  logic [7:0]                 alu_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [7:0]                 res_data,
  output logic [1:0]                 res_opcode,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int SW   = $clog2(SETTLE + 1);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [SW-1:0] SETTLE_LD  = SW'(SETTLE);
  localparam logic [SW-1:0] SETTLE_ONE = SW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // FIFO storage: {opcode, in2, in1}
  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  state_t        r_state;
  logic [SW-1:0] r_settle;
  logic [3:0]    r_alu_in1;
  logic [3:0]    r_alu_in2;
  logic [1:0]    r_alu_opcode;
  logic          r_res_valid;
  logic [7:0]    r_res_data;
  logic [1:0]    r_res_opcode;

  logic          w_not_full;
  logic          w_push;
  logic          w_pop;
  logic [9:0]    w_head;

  // Readiness comes from the registered count only, so a pop in the same
  // cycle does not free a slot for the producer until the next cycle.
  assign w_not_full = (r_count < FULL_COUNT);
  assign cmd_ready  = w_not_full & ~rst;
  assign w_push     = cmd_valid & cmd_ready;
  // The registered count excludes a push in the same cycle, so a command
  // is never popped on the edge that writes it.
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];

  // Command storage write; contents need no reset because count gates reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_opcode, cmd_in2, cmd_in1};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencing FSM with registered ALU operands and result port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_settle     <= '0;
      r_alu_in1    <= '0;
      r_alu_in2    <= '0;
      r_alu_opcode <= '0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_opcode <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_alu_in1    <= w_head[3:0];
            r_alu_in2    <= w_head[7:4];
            r_alu_opcode <= w_head[9:8];
            r_settle     <= SETTLE_LD;
            r_state      <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_settle <= r_settle - 1'b1;
          // Counter reaches zero on this edge: the ALU has settled.
          if (r_settle == SETTLE_ONE) begin
            r_res_data   <= alu_out;
            r_res_opcode <= r_alu_opcode;
            r_res_valid  <= 1'b1;
            r_state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (r_res_ready_accept(r_res_valid, res_ready)) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  function automatic logic r_res_ready_accept(input logic v, input logic r);
    return v & r;
  endfunction

  assign alu_in1    = r_alu_in1;
  assign alu_in2    = r_alu_in2;
  assign alu_opcode = r_alu_opcode;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_opcode = r_res_opcode;
  assign fifo_count = r_count;
  assign busy       = (r_state != S_IDLE);

endmodule
